// File: rtl/regbank_banco_if.sv
// Register bank bus: one write port, two independent read ports, and status.
//
// Request semantics: write_enable and read_enable_a/_b are single-cycle
// qualifiers sampled on the rising clock edge together with their
// address/data. No ready signal exists. A request made while busy=1 is not
// stalled: the bank drops a write, and a read returns 0. The master therefore
// waits for busy=0 before it issues real traffic. Read data appears on
// data_out_x one cycle after the request and then holds until the next
// enabled read on that port.
//
// state_dbg mirrors the internal FSM state (0 = CLEAR, 1 = READY).
interface regbank_banco_if #(
  parameter int BITS_WIDE = 32,
  parameter int ADDR_BITS = 5
);
  logic                 write_enable;
  logic [ADDR_BITS-1:0] write_addr;
  logic [BITS_WIDE-1:0] data_in;

  logic                 read_enable_a;
  logic [ADDR_BITS-1:0] read_addr_a;
  logic [BITS_WIDE-1:0] data_out_a;

  logic                 read_enable_b;
  logic [ADDR_BITS-1:0] read_addr_b;
  logic [BITS_WIDE-1:0] data_out_b;

  logic                 busy;
  logic                 state_dbg;

  modport master (
    output write_enable, write_addr, data_in,
    output read_enable_a, read_addr_a,
    output read_enable_b, read_addr_b,
    input  data_out_a, data_out_b, busy, state_dbg
  );

  modport slave (
    input  write_enable, write_addr, data_in,
    input  read_enable_a, read_addr_a,
    input  read_enable_b, read_addr_b,
    output data_out_a, data_out_b, busy, state_dbg
  );
endinterface

// File: rtl/regbank_banco.sv
// regbank_banco: 2**ADDR_BITS x BITS_WIDE register bank with one write port
// and two registered read ports.
//
// After reset the bank runs a clear sweep that zeroes one entry per cycle.
// busy is high during the sweep, and the bank takes no user traffic then.
// The entries have no direct reset, so they can map onto plain storage.
//
// Optional feature: define REGBANK_BYPASS_EN to make a same-edge read of the
// address being written return the new data (write-first). Without it, that
// read returns the old stored value (read-first).
module regbank_banco #(
  parameter int BITS_WIDE = 32,
  parameter int ADDR_BITS = 5,
  parameter int ZERO_REG  = 1
) (
  input  logic           clock,
  input  logic           reset_n,
  regbank_banco_if.slave bus
);

  localparam int                   DEPTH     = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [ADDR_BITS-1:0] clr_cnt_q;
  logic [ADDR_BITS-1:0] clr_cnt_d;

  // Storage array. It has no reset; only the clear sweep zeroes it.
  logic [BITS_WIDE-1:0] mem [DEPTH];

  // Single write path into the array, shared by the sweep and user writes.
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [BITS_WIDE-1:0] mem_wdata;

  // A user write that will actually land this edge.
  logic                 user_wr_ok;

  logic [BITS_WIDE-1:0] rd_data_a;
  logic [BITS_WIDE-1:0] rd_data_b;
  logic [BITS_WIDE-1:0] data_out_a_q;
  logic [BITS_WIDE-1:0] data_out_b_q;

  // True when addr names the hard-wired zero entry.
  function automatic logic is_zero_entry(input logic [ADDR_BITS-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // Qualify the user write: accepted only in READY and never at the zero entry.
  always_comb begin
    user_wr_ok = 1'b0;
    if (state_q == READY && bus.write_enable && !is_zero_entry(bus.write_addr)) begin
      user_wr_ok = 1'b1;
    end
  end

  // FSM state and sweep counter register; reset restarts the sweep from entry 0.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state and array write selection: the sweep owns the array in CLEAR,
  // and user writes own it in READY.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = READY;
        end
      end
      READY: begin
        if (user_wr_ok) begin
          mem_we    = 1'b1;
          mem_waddr = bus.write_addr;
          mem_wdata = bus.data_in;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Array write. Gating with reset_n drops any write that shares its edge
  // with a reset.
  always_ff @(posedge clock) begin
    if (reset_n && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Port A read value. It is 0 during the sweep and at the zero entry. The
  // optional bypass forwards a write landing on the same entry this edge.
  always_comb begin
    rd_data_a = '0;
    if (state_q == READY && !is_zero_entry(bus.read_addr_a)) begin
      rd_data_a = mem[bus.read_addr_a];
`ifdef REGBANK_BYPASS_EN
      if (user_wr_ok && bus.write_addr == bus.read_addr_a) begin
        rd_data_a = bus.data_in;
      end
`endif
    end
  end

  // Port B read value. It follows the same rules as port A, independently.
  always_comb begin
    rd_data_b = '0;
    if (state_q == READY && !is_zero_entry(bus.read_addr_b)) begin
      rd_data_b = mem[bus.read_addr_b];
`ifdef REGBANK_BYPASS_EN
      if (user_wr_ok && bus.write_addr == bus.read_addr_b) begin
        rd_data_b = bus.data_in;
      end
`endif
    end
  end

  // Registered read outputs. They load on an enabled read and otherwise hold.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_out_a_q <= '0;
      data_out_b_q <= '0;
    end else begin
      if (bus.read_enable_a) begin
        data_out_a_q <= rd_data_a;
      end
      if (bus.read_enable_b) begin
        data_out_b_q <= rd_data_b;
      end
    end
  end

  assign bus.data_out_a = data_out_a_q;
  assign bus.data_out_b = data_out_b_q;
  assign bus.busy       = (state_q == CLEAR);
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_regbank_banco.sv
// Directed testbench for regbank_banco (32 x 32, ZERO_REG=1).
// It builds with or without REGBANK_BYPASS_EN, and the expected
// same-edge read value follows the macro.
module tb_regbank_banco;

  logic clock;
  logic reset_n;

  regbank_banco_if #(.BITS_WIDE(32), .ADDR_BITS(5)) bus ();

  regbank_banco #(
    .BITS_WIDE(32),
    .ADDR_BITS(5),
    .ZERO_REG (1)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard state
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_qa[$];
  logic [31:0] exp_qb[$];
  logic [31:0] model_mem[32];
  logic [31:0] last_a;
  logic [31:0] last_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One edge: inputs change at the negedge, and outputs are sampled at the
  // following negedge.
  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    bus.write_enable  = 1'b0;
    bus.write_addr    = '0;
    bus.data_in       = '0;
    bus.read_enable_a = 1'b0;
    bus.read_addr_a   = '0;
    bus.read_enable_b = 1'b0;
    bus.read_addr_b   = '0;
  endtask

  // Reference read of the READY bank. A same-edge write is visible only
  // with the bypass macro.
  function automatic logic [31:0] model_read(input logic [4:0] ra, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (ra == 5'd0) return 32'h0;
`ifdef REGBANK_BYPASS_EN
    if (we && wa == ra) return wd;
`endif
    return model_mem[ra];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
    last_a = 32'h0;
    last_b = 32'h0;
  endtask

  // Driver for READY-phase traffic: push the expectations, apply one edge,
  // then pop and compare.
  task automatic drive(input string tag, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic rea, input logic [4:0] raa,
                       input logic reb, input logic [4:0] rab);
    logic [31:0] ea, eb;
    ea = rea ? model_read(raa, we, wa, wd) : last_a;
    eb = reb ? model_read(rab, we, wa, wd) : last_b;
    exp_qa.push_back(ea);
    exp_qb.push_back(eb);
    last_a = ea;
    last_b = eb;
    if (we && wa != 5'd0) model_mem[wa] = wd;
    bus.write_enable  = we;
    bus.write_addr    = wa;
    bus.data_in       = wd;
    bus.read_enable_a = rea;
    bus.read_addr_a   = raa;
    bus.read_enable_b = reb;
    bus.read_addr_b   = rab;
    cycle();
    if (exp_qa.size() == 0 || exp_qb.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      check({tag, "_a"}, bus.data_out_a, exp_qa.pop_front());
      check({tag, "_b"}, bus.data_out_b, exp_qb.pop_front());
    end
  endtask

  // Count the edges until busy drops, with a bound so the bench always ends.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      n++;
      if (!bus.busy) break;
    end
  endtask

  int n_busy;

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clock);
    cycle();
    cycle();

    // Reset state
    check("rst_out_a", bus.data_out_a, 32'h0);
    check("rst_out_b", bus.data_out_b, 32'h0);
    check("rst_busy", {31'h0, bus.busy}, 32'h1);
    check("rst_state", {31'h0, bus.state_dbg}, 32'h0);

    // Release reset. A write held on every sweep edge must be ignored.
    reset_n          = 1'b1;
    bus.write_enable = 1'b1;
    bus.write_addr   = 5'd5;
    bus.data_in      = 32'h99;
    count_busy(n_busy);
    check("sweep_len", n_busy, 32);
    check("ready_state", {31'h0, bus.state_dbg}, 32'h1);
    idle_inputs();
    model_clear();

    // Every entry reads 0 after the sweep; entry 5 includes the ignored write.
    for (int i = 0; i < 32; i++) begin
      drive("clear_rd", 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(31 - i));
    end

    // Write then read on both ports
    drive("wr7", 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    drive("rd7", 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);
    check("rd7_const", bus.data_out_a, 32'hDEADBEEF);

    // Zero entry ignores writes
    drive("wr0", 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0);
    drive("rd0", 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
    check("rd0_const", bus.data_out_b, 32'h0);
    drive("wr0_rd0", 1'b1, 5'd0, 32'h5A5A5A5A, 1'b1, 5'd0, 1'b1, 5'd0);

    // Same-edge read and write
    drive("wr3", 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 1'b0, 5'd0);
    drive("rw3", 1'b1, 5'd3, 32'h22, 1'b1, 5'd3, 1'b1, 5'd3);
`ifdef REGBANK_BYPASS_EN
    check("rw3_const", bus.data_out_a, 32'h22);
`else
    check("rw3_const", bus.data_out_a, 32'h11);
`endif
    drive("rd3", 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0);

    // Hold on a disabled port, while port B sees the new value
    drive("wr9", 1'b1, 5'd9, 32'hAA, 1'b0, 5'd0, 1'b0, 5'd0);
    drive("rd9", 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0);
    drive("wr9b", 1'b1, 5'd9, 32'h55, 1'b0, 5'd9, 1'b0, 5'd0);
    drive("hold9", 1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 1'b1, 5'd9);
    check("hold9_const", bus.data_out_a, 32'hAA);

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      drive("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
    end

    // Reset during READY with a write and a read pending
    drive("wr7c", 1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 5'd0);
    bus.write_enable  = 1'b1;
    bus.write_addr    = 5'd12;
    bus.data_in       = 32'h77;
    bus.read_enable_a = 1'b1;
    bus.read_addr_a   = 5'd7;
    bus.read_enable_b = 1'b1;
    bus.read_addr_b   = 5'd7;
    reset_n           = 1'b0;
    cycle();
    check("rst2_out_a", bus.data_out_a, 32'h0);
    check("rst2_out_b", bus.data_out_b, 32'h0);
    check("rst2_busy", {31'h0, bus.busy}, 32'h1);

    // During the sweep an enabled read returns 0 even for an entry not yet cleared.
    reset_n          = 1'b1;
    bus.write_enable = 1'b0;
    cycle();
    check("clr_rd7", bus.data_out_a, 32'h0);
    for (int i = 0; i < 9; i++) cycle();
    check("clr_busy10", {31'h0, bus.busy}, 32'h1);

    // Reset at clr_cnt = 10 restarts the full sweep
    reset_n = 1'b0;
    idle_inputs();
    cycle();
    check("rst3_busy", {31'h0, bus.busy}, 32'h1);
    reset_n = 1'b1;
    count_busy(n_busy);
    check("sweep_restart_len", n_busy, 32);
    model_clear();
    drive("post_rd7", 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd12);
    drive("post_rd9", 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd3);

    if (exp_qa.size() != 0 || exp_qb.size() != 0) begin
      check("queue_drained", 32'(exp_qa.size() + exp_qb.size()), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regbank_banco.md
REGBANK_BANCO -- requirements
Module: regbank_banco

Interface
REQ-001 The block SHALL have parameter BITS_WIDE, default 32, giving the data width of every entry.
REQ-002 The block SHALL have parameter ADDR_BITS, default 5, giving DEPTH = 2**ADDR_BITS entries.
REQ-003 The block SHALL have parameter ZERO_REG, default 1; when 1, entry 0 always reads 0 and ignores writes.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset_n  input  1  synchronous active-low reset.
REQ-007 write_enable  input  1  write request for write_addr.
REQ-008 write_addr  input  ADDR_BITS  write entry index.
REQ-009 data_in  input  BITS_WIDE  write data.
REQ-010 read_enable_a  input  1  read request, port A.
REQ-011 read_addr_a  input  ADDR_BITS  read entry index, port A.
REQ-012 data_out_a  output  BITS_WIDE  registered read data, port A.
REQ-013 read_enable_b  input  1  read request, port B.
REQ-014 read_addr_b  input  ADDR_BITS  read entry index, port B.
REQ-015 data_out_b  output  BITS_WIDE  registered read data, port B.
REQ-016 busy  output  1  high while the post-reset clear sweep runs.

Function
REQ-017 The block SHALL implement a two-state FSM, CLEAR and READY.
REQ-018 In CLEAR, the block SHALL write 0 to entry clr_cnt on each clock edge, increment clr_cnt, and move to READY on the edge that clears entry DEPTH-1.
REQ-019 busy SHALL be 1 in CLEAR and 0 in READY, so it stays high for exactly DEPTH cycles after reset release.
REQ-020 In CLEAR, the block SHALL ignore write_enable, and any enabled read port SHALL load 0.
REQ-021 In READY, on an edge with write_enable=1, the block SHALL store data_in at write_addr, except at entry 0 when ZERO_REG=1.
REQ-022 On an edge with read_enable_x=1, data_out_x SHALL load the contents of read_addr_x, with 1-cycle latency.
REQ-023 With read_enable_x=0, data_out_x SHALL hold its previous value; the outputs are never tri-stated.
REQ-024 Both read ports SHALL operate independently and simultaneously, including with the same address.
REQ-025 A read of entry 0 with ZERO_REG=1 SHALL return 0 regardless of any write.
REQ-026 A same-edge read and write to the same address SHALL follow the REGBANK_BYPASS_EN rule in REQ-031 and REQ-032.

Reset
REQ-027 On a clock edge with reset_n=0, the block SHALL set state=CLEAR, clr_cnt=0, data_out_a=0, data_out_b=0 and busy=1.
REQ-028 Entry contents SHALL NOT be reset directly; they are zeroed only by the CLEAR sweep.
REQ-029 If reset_n is asserted during CLEAR, the sweep SHALL restart from entry 0.
REQ-030 If reset_n is asserted during READY, any pending write on that edge SHALL be discarded.

Configuration
REQ-031 With macro REGBANK_BYPASS_EN defined, a same-edge read of the written address (not a ZERO_REG entry 0) SHALL return data_in (write-first).
REQ-032 Without REGBANK_BYPASS_EN, that read SHALL return the old stored value (read-first).

Verification
REQ-033 Release reset with DEPTH=32 -> busy=1 for exactly 32 cycles; then every read returns 0.
REQ-034 Write 0xDEADBEEF to entry 7, then read A=7 and B=7 on the next cycle -> both ports show 0xDEADBEEF one cycle later.
REQ-035 With ZERO_REG=1, write 0x12345678 to entry 0, then read entry 0 -> 0x00000000.
REQ-036 Entry 3 holds 0x11; on one edge write 0x22 to entry 3 and read entry 3 -> 0x22 with REGBANK_BYPASS_EN, 0x11 without it.
REQ-037 Deassert read_enable_a after reading 0xAA, then write the entry -> data_out_a holds 0xAA.
REQ-038 Assert reset_n=0 when clr_cnt=10 -> the sweep restarts and busy stays high for 32 more cycles.
